// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus types: request/response structs, size/length encodings and
// the beat-count helper used by every CBus endpoint.
package cbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } msize_t;

  // Burst length is carried as (beats - 1) so the field doubles as the
  // index of the final beat.
  typedef enum logic [3:0] {
    LEN_1  = 4'd0,
    LEN_2  = 4'd1,
    LEN_4  = 4'd3,
    LEN_8  = 4'd7,
    LEN_16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Number of beats (1..16) a length code describes.
  function automatic logic [4:0] beats_of(mlen_t len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/cbus_sram_array.sv
// Byte-strobed single-port word RAM: asynchronous read, synchronous write.
module cbus_sram_array #(
  parameter  int WORDS = 4096,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    strobe_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Write only the byte lanes whose strobe bit is set.
  // NOTE: storage arrays get no reset; clearing thousands of words would
  // force a flop-based implementation and contents are undefined at power-up.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus responder fronting a word-addressed SRAM with programmable first-beat
// latency and incrementing (wrapping) bursts of 1..16 beats.
// Optional: define CBUS_RESP_STALL_EN to insert pseudo-random beat stalls
// driven by a 16-bit LFSR.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter  int WORDS   = 4096,
  parameter  int LATENCY = 2,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT, ST_DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic          is_write_q, is_write_d;
  logic [3:0]    last_beat_q, last_beat_d;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    lat_q, lat_d;

  logic          stall;
  logic          beat_fire;
  logic          at_last;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;

  // size and the byte offset/high address bits play no part in addressing.
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};

`ifdef CBUS_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running x^16+x^14+x^13+x^11 LFSR; bit 0 decides a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign idx     = base_q + AW'(beat_q);
  assign at_last = (beat_q == last_beat_q);

  // Transaction state and burst bookkeeping registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      is_write_q  <= 1'b0;
      last_beat_q <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      is_write_q  <= is_write_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
    end
  end

  // Next-state, beat sequencing and response outputs.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    is_write_d  = is_write_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    beat_fire   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (creq.valid) begin
          base_d      = creq.addr[AW+1:2];
          is_write_d  = creq.is_write;
          last_beat_d = 4'(beats_of(creq.len) - 5'd1);
          beat_d      = '0;
          lat_d       = LAT_LOAD;
          state_d     = (LATENCY == 0) ? ST_BEAT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = ST_BEAT;
        else             lat_d   = lat_q - 4'd1;
      end
      ST_BEAT: begin
        if (!stall) begin
          beat_fire = 1'b1;
          if (at_last) state_d = ST_DONE;
          else         beat_d  = beat_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cresp.ready = beat_fire;
    cresp.last  = beat_fire && at_last;
    cresp.data  = (beat_fire && !is_write_q) ? rdata : 32'h0;
  end

  cbus_sram_array #(.WORDS(WORDS)) u_array (
    .clk      (clk),
    .we_i     (beat_fire && is_write_q),
    .idx_i    (idx),
    .strobe_i (creq.strobe),
    .wdata_i  (creq.data),
    .rdata_o  (rdata)
  );

`ifndef SYNTHESIS
  // The initiator must hold valid until the burst has completed.
  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    (state_q inside {ST_WAIT, ST_BEAT}) |-> creq.valid);
`endif

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Randomized bench for cbus_sram_responder against a word-array memory model.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int WORDS = 4096;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] tx_data [16];
  logic [3:0]  tx_strb [16];
  logic [31:0] rx_data [16];
  logic [31:0] old_w [4];
  logic [31:0] new_w [4];
  int          first_ready;
  int          last_ready;

  cbus_sram_responder #(.WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction from acceptance to back in IDLE. hold keeps valid high
  // through the DONE cycle; abort_beat >= 0 fires reset while that beat is ready.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input mlen_t len,
                         input bit hold, input int abort_beat);
    int n, k, c, base;
    n = int'(len) + 1;
    base = int'(addr[13:2]);
    k = 0; c = 0;
    first_ready = -1; last_ready = -1;
    creq.valid = 1'b1; creq.is_write = wr; creq.size = SZ_WORD;
    creq.addr = addr; creq.len = len;
    creq.data = tx_data[0]; creq.strobe = tx_strb[0];
    @(posedge clk); #1;
    // Scramble latched fields; the responder must ignore them now.
    creq.addr = $urandom;
    creq.len  = (len == LEN_1) ? LEN_16 : LEN_1;
    creq.size = SZ_BYTE;
    while (k < n) begin
      @(negedge clk); c++;
      if (c > 400) begin
        check("timeout", 32'(c), 32'(0));
        creq.valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        return;
      end
      if (cresp.ready) begin
        if (first_ready < 0) first_ready = c;
        last_ready = c;
        check("last", 32'(cresp.last), 32'(k == n - 1));
        if (!wr) begin
          check("rdata", cresp.data, model_mem[(base + k) % WORDS]);
          rx_data[k] = cresp.data;
        end
        if (k == abort_beat) begin
          reset = 1'b1; #1;
          check("abort_ready", 32'(cresp.ready), 32'(0));
          check("abort_last",  32'(cresp.last),  32'(0));
          check("abort_data",  cresp.data, 32'h0);
          creq.valid = 1'b0;
          repeat (2) @(posedge clk);
          #1 reset = 1'b0;
          @(posedge clk); #1;
          return;
        end
        @(posedge clk); #1;
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (tx_strb[k][i]) model_mem[(base + k) % WORDS][8*i +: 8] = tx_data[k][8*i +: 8];
        end
        k++;
        if (k < n) begin creq.data = tx_data[k]; creq.strobe = tx_strb[k]; end
      end else begin
        check("gap_last", 32'(cresp.last), 32'(0));
        check("gap_data", cresp.data, 32'h0);
      end
    end
    if (!hold) creq.valid = 1'b0;
    @(negedge clk);
    check("done_ready", 32'(cresp.ready), 32'(0));
    check("done_last",  32'(cresp.last),  32'(0));
    if (hold) begin
      @(posedge clk); #1 creq.valid = 1'b0;
      repeat (LAT + 3) begin
        @(negedge clk);
        check("no_reaccept", 32'(cresp.ready), 32'(0));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_latency(input string tag);
`ifndef CBUS_RESP_STALL_EN
    check(tag, 32'(first_ready), 32'(LAT + 1));
`else
    check(tag, 32'(first_ready >= LAT + 1), 32'(1));
`endif
  endtask

  initial begin
    mlen_t lens [5];
    lens[0] = LEN_1; lens[1] = LEN_2; lens[2] = LEN_4; lens[3] = LEN_8; lens[4] = LEN_16;

    reset = 1'b1;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cresp.ready), 32'(0));
    check("rst_last",  32'(cresp.last),  32'(0));
    check("rst_data",  cresp.data, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill words 0..63 so every later read hits known contents.
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 16; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'hF; end
      run_txn(1'b1, 32'(w * 64), LEN_16, 1'b0, -1);
    end

    // Single write then read at 0x10.
    tx_data[0] = 32'hDEADBEEF; tx_strb[0] = 4'hF;
    run_txn(1'b1, 32'h10, LEN_1, 1'b0, -1);
    check_latency("wr_latency");
    run_txn(1'b0, 32'h10, LEN_1, 1'b0, -1);
    check_latency("rd_latency");
    check("rd_deadbeef", rx_data[0], 32'hDEADBEEF);

    // Partial strobe merge.
    tx_data[0] = 32'hAABBCCDD; tx_strb[0] = 4'hF;
    run_txn(1'b1, 32'h10, LEN_1, 1'b0, -1);
    tx_data[0] = 32'h11223344; tx_strb[0] = 4'b0101;
    run_txn(1'b1, 32'h10, LEN_1, 1'b0, -1);
    run_txn(1'b0, 32'h10, LEN_1, 1'b0, -1);
    check("partial", rx_data[0], 32'hAA22CC44);

    // 16-beat burst: words 16..31 hold 0..15.
    for (int k = 0; k < 16; k++) begin tx_data[k] = 32'(k); tx_strb[k] = 4'hF; end
    run_txn(1'b1, 32'h40, LEN_16, 1'b0, -1);
    run_txn(1'b0, 32'h40, LEN_16, 1'b0, -1);
    for (int k = 0; k < 16; k++) check("burst16", rx_data[k], 32'(k));
`ifndef CBUS_RESP_STALL_EN
    check("burst16_span", 32'(last_ready - first_ready), 32'(15));
`endif

    // Wrap at the end of the array: 4094, 4095, 0, 1.
    for (int k = 0; k < 4; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'hF; new_w[k] = tx_data[k]; end
    run_txn(1'b1, 32'(4094 * 4), LEN_4, 1'b0, -1);
    run_txn(1'b0, 32'(4094 * 4), LEN_4, 1'b0, -1);
    run_txn(1'b0, 32'h0, LEN_2, 1'b0, -1);
    check("wrap_w0", rx_data[0], new_w[2]);
    check("wrap_w1", rx_data[1], new_w[3]);

    // Valid held through DONE must not start a second transaction.
    run_txn(1'b0, 32'h10, LEN_1, 1'b1, -1);
    for (int k = 0; k < 2; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'hF; end
    run_txn(1'b1, 32'h20, LEN_2, 1'b0, -1);
    run_txn(1'b0, 32'h20, LEN_2, 1'b0, -1);

    // Reset during beat 2 of a 4-beat write at words 100..103.
    for (int k = 0; k < 4; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'hF; old_w[k] = tx_data[k]; end
    run_txn(1'b1, 32'(100 * 4), LEN_4, 1'b0, -1);
    for (int k = 0; k < 4; k++) begin tx_data[k] = ~old_w[k]; new_w[k] = tx_data[k]; end
    run_txn(1'b1, 32'(100 * 4), LEN_4, 1'b0, 2);
    run_txn(1'b0, 32'(100 * 4), LEN_4, 1'b0, -1);
    check("abort_b0", rx_data[0], new_w[0]);
    check("abort_b1", rx_data[1], new_w[1]);
    check("abort_b2", rx_data[2], old_w[2]);
    check("abort_b3", rx_data[3], old_w[3]);

    // Random traffic inside the initialised window.
    for (int t = 0; t < 40; t++) begin
      bit          wr;
      logic [31:0] a;
      mlen_t       len;
      wr  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 47) * 4 + $urandom_range(0, 3));
      len = lens[$urandom_range(0, 4)];
      for (int k = 0; k < 16; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'($urandom); end
      run_txn(wr, a, len, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
